step_clock_controller: RTL and testbench

STEP_CLOCK_CONTROLLER -- requirements
Module: step_clock_controller

---
 rtl/step_ctrl_pkg.sv | 18 +
 rtl/key_debouncer.sv | 66 ++++++
 rtl/step_clock_controller.sv | 128 ++++++++++++
 tb/tb_step_clock_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the single-step / auto-run clock controller.
package step_ctrl_pkg;

   typedef enum logic [1:0] {
      MANUAL = 2'd0,
      RUN    = 2'd1,
      HALT   = 2'd2
   } state_t;

   // Auto-run step rates in Hz, indexed by sw_rate.
   localparam int unsigned RATE_HZ [4] = '{1, 10, 100, 1000};

   // Terminal prescaler count for a given rate: CLK_HZ/RATE cycles per step.
   function automatic int unsigned rate_term(input int unsigned clk_hz, input int unsigned idx);
      return (clk_hz / RATE_HZ[idx]) - 1;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus counter debouncer for an active-low pushbutton.
// Emits a one-cycle press strobe on an accepted released->pressed change.
module key_debouncer
   import step_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [1:0]    fill_q, fill_d;
   logic          level_q, level_d;
   logic          armed_q, armed_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync_d  = {sync_q[0], key_n};
      fill_d  = {fill_q[0], 1'b1};
      level_d = level_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      // A key held through reset must be seen released before a press can count.
      armed_d = armed_q | (fill_q[1] & sync_q[1] & level_q);
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync_q[1];
         cnt_d   = '0;
         press_d = level_q & armed_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // NOTE: state flops use non-blocking assignments and reset asynchronously to the released/zero values.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         fill_q  <= 2'b00;
         level_q <= 1'b1;
         armed_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         fill_q  <= fill_d;
         level_q <= level_d;
         armed_q <= armed_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/step_clock_controller.sv
// Step-clock controller: manual single-step, prescaled auto-run and halt,
// producing one-cycle step_en pulses and a wrapping step counter.
module step_clock_controller
   import step_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ          = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        key_step_n,
   input  logic        sw_run,
   input  logic [1:0]  sw_rate,
   input  logic        halt_req,
   input  logic        halt_clr,
   output logic        step_en,
   output logic [15:0] step_count,
   output logic        running,
   output logic        halted
);

   localparam logic [31:0] TERM_0 = rate_term(CLK_HZ, 0);
   localparam logic [31:0] TERM_1 = rate_term(CLK_HZ, 1);
   localparam logic [31:0] TERM_2 = rate_term(CLK_HZ, 2);
   localparam logic [31:0] TERM_3 = rate_term(CLK_HZ, 3);

   logic        key_level;
   logic        key_press;
   logic [31:0] term;

   state_t      state_q, state_d;
   logic        step_en_q, step_en_d;
   logic [15:0] count_q, count_d;
   logic [31:0] presc_q, presc_d;
   logic [1:0]  rate_q;
   logic        running_q, running_d;
   logic        halted_q, halted_d;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .key_n    (key_step_n),
      .level    (key_level),
      .press    (key_press)
   );

   always_comb begin
      case (sw_rate)
         2'd0:    term = TERM_0;
         2'd1:    term = TERM_1;
         2'd2:    term = TERM_2;
         default: term = TERM_3;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      step_en_d = 1'b0;
      presc_d   = presc_q;
      case (state_q)
         MANUAL: begin
            if (halt_req) begin
               state_d = HALT;
            end else if (sw_run) begin
               state_d = RUN;
               presc_d = '0;
            end else begin
               step_en_d = key_press;
            end
         end
         RUN: begin
            // Halt and mode changes take priority over a prescaler tick.
            if (halt_req) begin
               state_d = HALT;
               presc_d = '0;
            end else if (!sw_run) begin
               state_d = MANUAL;
               presc_d = '0;
            end else if (sw_rate != rate_q) begin
               presc_d = '0;
            end else if (presc_q >= term) begin
               presc_d   = '0;
               step_en_d = 1'b1;
            end else begin
               presc_d = presc_q + 32'd1;
            end
         end
         HALT: begin
            if (halt_clr && !halt_req) begin
               state_d = sw_run ? RUN : MANUAL;
               presc_d = '0;
            end
         end
         default: state_d = MANUAL;
      endcase
      // At the fastest rate this spaces pulses at least one idle cycle apart.
      step_en_d = step_en_d & ~step_en_q;
      count_d   = count_q + {15'd0, step_en_d};
      running_d = (state_d == RUN);
      halted_d  = (state_d == HALT);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= MANUAL;
         step_en_q <= 1'b0;
         count_q   <= '0;
         presc_q   <= '0;
         rate_q    <= '0;
         running_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_en_q <= step_en_d;
         count_q   <= count_d;
         presc_q   <= presc_d;
         rate_q    <= sw_rate;
         running_q <= running_d;
         halted_q  <= halted_d;
      end
   end

   assign step_en    = step_en_q;
   assign step_count = count_q;
   assign running    = running_q;
   assign halted     = halted_q;

endmodule

// File: tb/tb_step_clock_controller.sv
// Scoreboard bench for step_clock_controller: expected pulses (cycle, count)
// are queued as stimulus is applied and matched as step_en appears.
module tb_step_clock_controller;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic        key_step_n;
   logic        sw_run;
   logic [1:0]  sw_rate;
   logic        halt_req;
   logic        halt_clr;
   logic        step_en;
   logic [15:0] step_count;
   logic        running;
   logic        halted;

   typedef struct {
      int unsigned cyc;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_total = 0;
   int          n_bad = 0;
   logic        prev_step = 1'b0;

   step_clock_controller #(.CLK_HZ(1000), .DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .key_step_n (key_step_n),
      .sw_run     (sw_run),
      .sw_rate    (sw_rate),
      .halt_req   (halt_req),
      .halt_clr   (halt_clr),
      .step_en    (step_en),
      .step_count (step_count),
      .running    (running),
      .halted     (halted)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) tick(1);
   endtask

   // Pulse monitor: every step_en must match the head of the scoreboard.
   always @(negedge CLOCK_50) begin
      exp_t e;
      if (!reset) begin
         if (step_en) begin
            check("no_back_to_back", {31'd0, prev_step}, 0);
            if (sb.size() == 0) begin
               check("spurious_step", {31'd0, step_en}, 0);
            end else begin
               e = sb.pop_front();
               check("step_cycle", cyc, e.cyc);
               check("step_count_at_pulse", {16'd0, step_count}, {16'd0, e.cnt});
            end
         end
         prev_step = step_en;
      end else begin
         prev_step = 1'b0;
      end
   end

   initial begin
      int unsigned c0, r0, h;
      reset = 1'b1; key_step_n = 1'b1; sw_run = 1'b0; sw_rate = 2'd0;
      halt_req = 1'b0; halt_clr = 1'b0;

      // Reset state
      tick(3);
      @(negedge CLOCK_50);
      check("rst_step_en", {31'd0, step_en}, 0);
      check("rst_count", {16'd0, step_count}, 0);
      check("rst_running", {31'd0, running}, 0);
      check("rst_halted", {31'd0, halted}, 0);
      tick(1);
      reset = 1'b0;
      tick(5);

      // Manual step: sync(2) + debounce(4) + registered step = 7 cycles
      c0 = cyc;
      key_step_n = 1'b0;
      sb.push_back('{cyc: c0 + 7, cnt: 16'd1});
      tick(10);
      key_step_n = 1'b1;
      tick(20);
      check("manual_sb_empty", sb.size(), 0);
      check("manual_count", {16'd0, step_count}, 1);

      // Bounce rejection
      for (int i = 0; i < 5; i++) begin
         key_step_n = 1'b0; tick(2);
         key_step_n = 1'b1; tick(2);
      end
      tick(20);
      check("bounce_count", {16'd0, step_count}, 1);

      // Wrap at divisor 1: pulses every other cycle, 65535 more steps -> 0
      sw_rate = 2'd3; sw_run = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 65535; i++)
         sb.push_back('{cyc: c0 + 2 + 2 * i, cnt: 16'(2 + i)});
      tick(3);
      check("fast_running", {31'd0, running}, 1);
      wait_until(c0 + 131070);
      sw_run = 1'b0;
      tick(10);
      check("wrap_sb_empty", sb.size(), 0);
      check("wrap_count", {16'd0, step_count}, 0);
      check("manual_after_run", {31'd0, running}, 0);

      // Auto-run at divisor 1000
      sw_rate = 2'd0; sw_run = 1'b1;
      r0 = cyc;
      for (int i = 0; i < 3; i++)
         sb.push_back('{cyc: r0 + 1001 + 1000 * i, cnt: 16'(1 + i)});
      wait_until(r0 + 3005);
      check("run_sb_empty", sb.size(), 0);
      check("run_running", {31'd0, running}, 1);
      check("run_halted", {31'd0, halted}, 0);

      // Halt on the cycle the 4th step is due
      wait_until(r0 + 4000);
      halt_req = 1'b1;
      tick(1);
      halt_req = 1'b0;
      check("halt_halted", {31'd0, halted}, 1);
      check("halt_running", {31'd0, running}, 0);
      tick(8);
      check("halt_count", {16'd0, step_count}, 3);
      h = cyc;
      halt_clr = 1'b1;
      tick(1);
      halt_clr = 1'b0;
      check("clr_running", {31'd0, running}, 1);
      check("clr_halted", {31'd0, halted}, 0);
      sb.push_back('{cyc: h + 1001, cnt: 16'd4});
      wait_until(h + 1200);
      check("clr_sb_empty", sb.size(), 0);

      // Reset at prescaler 500 with the key held through reset
      wait_until(h + 1501);
      key_step_n = 1'b0; sw_run = 1'b0;
      reset = 1'b1;
      #1;
      check("midrst_step_en", {31'd0, step_en}, 0);
      check("midrst_count", {16'd0, step_count}, 0);
      check("midrst_running", {31'd0, running}, 0);
      check("midrst_halted", {31'd0, halted}, 0);
      tick(5);
      reset = 1'b0;
      tick(20);
      key_step_n = 1'b1;
      tick(20);
      check("held_key_count", {16'd0, step_count}, 0);

      // Fresh press after release still steps
      c0 = cyc;
      key_step_n = 1'b0;
      sb.push_back('{cyc: c0 + 7, cnt: 16'd1});
      tick(10);
      key_step_n = 1'b1;
      tick(20);
      check("final_sb_empty", sb.size(), 0);
      check("final_count", {16'd0, step_count}, 1);
      check("final_running", {31'd0, running}, 0);
      check("final_halted", {31'd0, halted}, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
